k12_seq: RTL and testbench
==========================

K12_SEQ -- requirements
Module: k12_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 mem_addr  out  8  instruction-memory byte address (= PC).
REQ-005 mem_req  out  1  fetch request, high in FETCH_HI/FETCH_LO only.
REQ-006 mem_ack  in  1  memory has valid mem_rdata this cycle.
REQ-007 mem_rdata  in  8  instruction byte.
REQ-008 inst  out  16  instruction register, driven to the ALU.
REQ-009 a  out  8  accumulator ACC, driven to ALU operand A.
REQ-010 b  out  8  R[inst[2:0]], driven to ALU operand B.
REQ-011 res  in  8  ALU result, combinational from inst/a/b.
REQ-012 cond  in  1  ALU condition, combinational from inst/a/b.
REQ-013 halted  out  1  high in the HALT state.

Function
REQ-014 State machine: FETCH_HI -> FETCH_LO -> EXEC -> FETCH_HI, plus HALT; each fetch state waits indefinitely for mem_ack.
REQ-015 FETCH_HI: on mem_ack, inst[15:8] <= mem_rdata, PC <= PC+1, go to FETCH_LO.
REQ-016 FETCH_LO: on mem_ack, inst[7:0] <= mem_rdata, PC <= PC+1, go to EXEC.
REQ-017 PC SHALL be 8 bits and wrap 0xFF -> 0x00 without error; instructions straddling the wrap are legal.
REQ-018 EXEC SHALL last exactly one cycle and sample res/cond at its end, giving a latency of 3 cycles per instruction with zero-wait memory.
REQ-019 Class inst[15:14]=00 (ALU): ACC <= res.
REQ-020 Class 01 (SKIP): when cond=1, set skip flag; the next instruction is fetched and discarded (no state change except PC), then the flag clears.
REQ-021 Class 10 (JUMP): when cond=1, PC <= inst[7:0]; otherwise no effect.
REQ-022 Class 11, inst[13]=0 (STORE): R[inst[2:0]] <= ACC.
REQ-023 Class 11, inst[13]=1 (HALT): go to HALT; HALT is left only by reset; mem_req=0 in HALT.
REQ-024 A skipped instruction SHALL never halt, jump, store, set skip or write ACC, including a skipped SKIP.
REQ-025 JUMP to the current PC SHALL loop without error.
REQ-026 mem_rdata SHALL be ignored on any cycle in which mem_ack=0 or the state is not a fetch state.

Reset
REQ-027 While rst_n=0: PC=0x00, ACC=0x00, R0-R7=0x00, inst=0x0000, skip=0, state=FETCH_HI, mem_req=0, halted=0.
REQ-028 Reset asserted mid-fetch or in EXEC SHALL abandon the instruction without committing it.
REQ-029 After reset release, mem_req SHALL rise on the first clock edge, and the first fetch address SHALL be 0x00.

Configuration
REQ-030 Macro K12_SEQ_RETIRE_CNT_EN: when defined, add output retired[15:0], which increments on every non-skipped EXEC, resets to 0, wraps 0xFFFF->0x0000, and does not count HALT itself.
REQ-031 Without K12_SEQ_RETIRE_CNT_EN: the retired port and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-032 Package k12_pkg SHALL hold the state enum (FETCH_HI, FETCH_LO, EXEC, HALT), the class encodings (CLS_ALU=2'b00, CLS_SKIP=2'b01, CLS_JUMP=2'b10, CLS_MISC=2'b11) and the register-count constant NREG=8.
REQ-033 Sub-module k12_regfile SHALL be an 8x8 register file with one asynchronous read port, one synchronous write port and asynchronous reset.

Verification
REQ-034 Reset release with mem_ack tied high -> mem_addr sequence 0x00, 0x01, then EXEC; inst equals the two bytes, big-endian.
REQ-035 ALU op, ALU model res=0x5A -> ACC=0x5A at the end of EXEC; a STORE to R3 then makes b=0x5A when inst[2:0]=3.
REQ-036 SKIP with cond=1 at PC 0x10 -> the instruction at 0x12 is fetched but ACC is unchanged; execution resumes at 0x14. With cond=0 -> the instruction at 0x12 executes.
REQ-037 JUMP 0x40 with cond=1 -> next mem_addr=0x40; with cond=0 -> next mem_addr=PC+2.
REQ-038 Instruction at 0xFF/0x00 -> PC wraps to 0x01 after the fetch; mem_ack held low for 5 cycles in FETCH_LO -> state holds and inst[7:0] is unchanged.
REQ-039 HALT -> halted=1 and mem_req=0 forever; rst_n pulsed low mid-FETCH_LO -> all REQ-027 values, and retired=0 when K12_SEQ_RETIRE_CNT_EN is defined.

Source files
------------

// File: rtl/k12_pkg.sv
// Shared types and constants for the k12_seq instruction sequencer.
package k12_pkg;

  localparam int NREG = 8;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    EXEC     = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_SKIP = 2'b01;
  localparam logic [1:0] CLS_JUMP = 2'b10;
  localparam logic [1:0] CLS_MISC = 2'b11;

  function automatic logic is_fetch(input state_t s);
    return (s == FETCH_HI) || (s == FETCH_LO);
  endfunction

endpackage

// File: rtl/k12_seq_if.sv
// Instruction-memory fetch port plus the ALU operand/result port of k12_seq.
// Fetch handshake: mem_req marks a fetch cycle, and a byte is consumed only on a
// rising edge where mem_req and mem_ack are both high; mem_rdata is don't-care otherwise.
interface k12_seq_if;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] inst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  res;
  logic        cond;

  modport master (
    output mem_addr, mem_req, inst, a, b,
    input  mem_ack, mem_rdata, res, cond
  );

  modport slave (
    input  mem_addr, mem_req, inst, a, b,
    output mem_ack, mem_rdata, res, cond
  );
endinterface

// File: rtl/k12_regfile.sv
// 8x8 register file: asynchronous read, synchronous write, asynchronous reset.
module k12_regfile
  import k12_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata = regs_q[raddr];

endmodule

// File: rtl/k12_seq.sv
// Two-byte fetch / one-cycle execute sequencer with an external ALU.
// Optional retired-instruction counter enabled by K12_SEQ_RETIRE_CNT_EN.
module k12_seq
  import k12_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  k12_seq_if.master    bus,
  output logic         halted,
  output state_t       state_dbg
`ifdef K12_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]  retired
`endif
);

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  acc_q, acc_d;
  logic [15:0] inst_q, inst_d;
  logic        skip_q, skip_d;
  logic        started_q;
  logic        rf_we;
  logic        fetch_go;

  // started_q holds mem_req low until the first edge after reset release.
  assign fetch_go      = started_q && bus.mem_ack;
  assign bus.mem_req   = started_q && is_fetch(state_q);
  assign bus.mem_addr  = pc_q;
  assign bus.inst      = inst_q;
  assign bus.a         = acc_q;
  assign halted        = (state_q == HALT);
  assign state_dbg     = state_q;

  k12_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (inst_q[2:0]),
    .wdata (acc_q),
    .raddr (inst_q[2:0]),
    .rdata (bus.b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH_HI;
      pc_q      <= '0;
      acc_q     <= '0;
      inst_q    <= '0;
      skip_q    <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      inst_q    <= inst_d;
      skip_q    <= skip_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    inst_d  = inst_q;
    skip_d  = skip_q;
    rf_we   = 1'b0;
    case (state_q)
      FETCH_HI: begin
        if (fetch_go) begin
          inst_d[15:8] = bus.mem_rdata;
          pc_d         = pc_q + 8'd1;
          state_d      = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (fetch_go) begin
          inst_d[7:0] = bus.mem_rdata;
          pc_d        = pc_q + 8'd1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH_HI;
        // A skipped instruction only consumes its fetch; it commits nothing.
        if (skip_q) begin
          skip_d = 1'b0;
        end else begin
          case (inst_q[15:14])
            CLS_ALU:  acc_d = bus.res;
            CLS_SKIP: if (bus.cond) skip_d = 1'b1;
            CLS_JUMP: if (bus.cond) pc_d = inst_q[7:0];
            default: begin
              if (inst_q[13]) state_d = HALT;
              else            rf_we   = 1'b1;
            end
          endcase
        end
      end
      default: state_d = HALT;
    endcase
  end

`ifdef K12_SEQ_RETIRE_CNT_EN
  logic halt_inst;
  assign halt_inst = (inst_q[15:14] == CLS_MISC) && inst_q[13];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if ((state_q == EXEC) && !skip_q && !halt_inst) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_k12_seq.sv
// Self-checking bench for k12_seq: directed program with literal expectations,
// then randomized programs checked every cycle against an instruction-level model.
module tb_k12_seq;
  import k12_pkg::*;

  logic clk;
  logic rst_n;
  logic halted;
  state_t state_dbg;
`ifdef K12_SEQ_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  k12_seq_if bus();

  k12_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .halted    (halted),
    .state_dbg (state_dbg)
`ifdef K12_SEQ_RETIRE_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ALU stand-in: res is an immediate or a^b, cond an immediate bit or a[0]
  function automatic logic [8:0] alu_f(input logic [15:0] i, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    logic       c;
    r = i[3] ? (x ^ y) : i[11:4];
    c = i[11] ? x[0] : i[12];
    return {c, r};
  endfunction

  logic [8:0] alu_o;
  assign alu_o    = alu_f(bus.inst, bus.a, bus.b);
  assign bus.res  = alu_o[7:0];
  assign bus.cond = alu_o[8];

  // memory responder, driven on the falling edge
  logic [7:0] mem [256];
  int ack_mode = 1;
  always @(negedge clk) begin
    logic ack;
    case (ack_mode)
      0:       ack = ($urandom_range(0, 9) < 7);
      1:       ack = 1'b1;
      default: ack = 1'b0;
    endcase
    bus.mem_ack   = ack;
    bus.mem_rdata = ack ? mem[bus.mem_addr] : 8'($urandom);
  end

  // instruction-level reference model
  logic [7:0]  m_pc, m_acc;
  logic [7:0]  m_reg [8];
  logic [15:0] m_inst;
  logic        m_skip, m_started;
  int          m_phase;
  logic [15:0] m_ret;
  logic [15:0] exp_q [$];
  logic [8:0]  m_alu;
  assign m_alu = alu_f(m_inst, m_acc, m_reg[m_inst[2:0]]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= '0; m_acc <= '0; m_inst <= '0; m_skip <= 1'b0;
      m_started <= 1'b0; m_phase <= 0; m_ret <= '0;
      for (int i = 0; i < 8; i++) m_reg[i] <= '0;
      exp_q.delete();
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else begin
      case (m_phase)
        0: if (bus.mem_ack) begin
             m_inst[15:8] <= mem[m_pc];
             m_pc <= m_pc + 8'd1;
             m_phase <= 1;
           end
        1: if (bus.mem_ack) begin
             m_inst[7:0] <= mem[m_pc];
             exp_q.push_back({m_inst[15:8], mem[m_pc]});
             m_pc <= m_pc + 8'd1;
             m_phase <= 2;
           end
        2: begin
             m_phase <= 0;
             if (m_skip) m_skip <= 1'b0;
             else if (m_inst[15:13] == 3'b111) m_phase <= 3;
             else begin
               m_ret <= m_ret + 16'd1;
               if (m_inst[15:14] == 2'b00) m_acc <= m_alu[7:0];
               else if (m_inst[15:14] == 2'b01) m_skip <= m_alu[8];
               else if (m_inst[15:14] == 2'b10) begin
                 if (m_alu[8]) m_pc <= m_inst[7:0];
               end else m_reg[m_inst[2:0]] <= m_acc;
             end
           end
        default: ;
      endcase
    end
  end

  // scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    logic exp_req;
    exp_req = m_started && (m_phase < 2);
    chk("mem_req", 16'(bus.mem_req), 16'(exp_req));
    if (exp_req) chk("mem_addr", 16'(bus.mem_addr), 16'(m_pc));
    chk("halted", 16'(halted), 16'(m_phase == 3));
    chk("state", 16'(state_dbg), 16'(m_phase));
    chk("inst", bus.inst, m_inst);
    chk("acc", 16'(bus.a), 16'(m_acc));
    chk("b", 16'(bus.b), 16'(m_reg[m_inst[2:0]]));
`ifdef K12_SEQ_RETIRE_CNT_EN
    chk("retired", retired, m_ret);
`endif
    if (m_phase == 2 && exp_q.size() > 0) chk("exec_inst", bus.inst, exp_q.pop_front());
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h00], mem[8'h01]} = 16'h05A0;  // ALU acc=5A
    {mem[8'h02], mem[8'h03]} = 16'hC003;  // STORE R3
    {mem[8'h04], mem[8'h05]} = 16'h9010;  // JUMP 10, cond=1
    {mem[8'h10], mem[8'h11]} = 16'h5000;  // SKIP cond=1
    {mem[8'h12], mem[8'h13]} = 16'h0770;  // ALU acc=77 (skipped)
    {mem[8'h14], mem[8'h15]} = 16'h4000;  // SKIP cond=0
    {mem[8'h16], mem[8'h17]} = 16'h0330;  // ALU acc=33
    {mem[8'h18], mem[8'h19]} = 16'h8040;  // JUMP 40, cond=0
    {mem[8'h1A], mem[8'h1B]} = 16'h9040;  // JUMP 40, cond=1
    {mem[8'h40], mem[8'h41]} = 16'h90FF;  // JUMP FF, cond=1
    mem[8'hFF] = 8'hE0;                   // with mem[00]: HALT 0xE005
  endtask

  task automatic mid_fetch_lo_reset();
    int n;
    n = 0;
    while (state_dbg != FETCH_LO && !halted && n < 80) begin step(); n++; end
    if (n >= 80) begin
      n_chk++;
      $display("FAIL wait_fetch_lo: got timeout expected FETCH_LO at %0t", $time);
    end else if (!halted) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mem_req", 16'(bus.mem_req), 16'h0);
      chk("rst_mem_addr", 16'(bus.mem_addr), 16'h0);
      chk("rst_inst", bus.inst, 16'h0000);
      chk("rst_acc", 16'(bus.a), 16'h0);
      chk("rst_b", 16'(bus.b), 16'h0);
      chk("rst_halted", 16'(halted), 16'h0);
      chk("rst_state", 16'(state_dbg), 16'(FETCH_HI));
`ifdef K12_SEQ_RETIRE_CNT_EN
      chk("rst_retired", retired, 16'h0000);
`endif
      @(negedge clk);
      #2 rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ack_mode = 1;
    load_program();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("req_before_edge", 16'(bus.mem_req), 16'h0);

    step(); chk("first_req", 16'(bus.mem_req), 16'h1); chk("first_addr", 16'(bus.mem_addr), 16'h00);
    step(); chk("second_addr", 16'(bus.mem_addr), 16'h01);
    step(); chk("exec_state", 16'(state_dbg), 16'(EXEC)); chk("inst_be", bus.inst, 16'h05A0);
    step(); chk("alu_acc", 16'(bus.a), 16'h5A);
    repeat (3) step();
    chk("store_inst", bus.inst, 16'hC003); chk("store_b", 16'(bus.b), 16'h5A);
    repeat (3) step(); chk("jump_taken", 16'(bus.mem_addr), 16'h10);
    repeat (6) step(); chk("skip_acc", 16'(bus.a), 16'h5A); chk("skip_resume", 16'(bus.mem_addr), 16'h14);
    repeat (6) step(); chk("noskip_acc", 16'(bus.a), 16'h33);
    repeat (3) step(); chk("jump_not_taken", 16'(bus.mem_addr), 16'h1A);
    repeat (3) step(); chk("jump_40", 16'(bus.mem_addr), 16'h40);
    step(); chk("lo_state", 16'(state_dbg), 16'(FETCH_LO)); chk("lo_addr", 16'(bus.mem_addr), 16'h41);
    ack_mode = 2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_state", 16'(state_dbg), 16'(FETCH_LO));
      chk("stall_inst_lo", 16'(bus.inst[7:0]), 16'h40);
    end
    ack_mode = 1;
    step(); chk("jump_ff_inst", bus.inst, 16'h90FF);
    step(); chk("jump_ff_addr", 16'(bus.mem_addr), 16'hFF);
    step(); step();
    chk("wrap_inst", bus.inst, 16'hE005); chk("wrap_pc", 16'(bus.mem_addr), 16'h01);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("halt_flag", 16'(halted), 16'h1);
      chk("halt_req", 16'(bus.mem_req), 16'h0);
    end

    // randomized programs
    for (int ep = 0; ep < 12; ep++) begin
      @(posedge clk);
      #3 rst_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
        mem[i] = 8'($urandom);
        if (mem[i][7:5] == 3'b111 && $urandom_range(0, 3) != 0) mem[i][5] = 1'b0;
      end
      ack_mode = (ep % 3 == 0) ? 1 : 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      if (ep % 2 == 1) begin
        repeat ($urandom_range(0, 20)) step();
        mid_fetch_lo_reset();
      end
      repeat (400) @(posedge clk);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
